// File: rtl/bp_perceptron_trainer_if.sv
// ---------------------------------------------------------------------------
// bp_perceptron_trainer_if
// Bundles the fetch-side snapshot push, the execute-side resolve, the flush
// and the predictor update/write-back outputs of bp_perceptron_trainer.
//
//   master modport : fetch/execute side (drives fetch_*, resolve_*, flush)
//   slave  modport : the trainer (drives full, update_*, err_flags)
//
// Signals:
//   fetch_valid/pc/ghr/weights/sum/pred_dir : prediction snapshot push
//   resolve_valid/pc4/dir                   : oldest branch resolved
//   flush                                   : discard in-flight snapshots
//   full                                    : snapshot FIFO full
//   update_valid/pc4/dir/miss/data          : trained row for write-back
//   err_flags                               : sticky {pc_mismatch, underflow, overflow}
// ---------------------------------------------------------------------------
interface bp_perceptron_trainer_if #(
    parameter int GHR_W = 12
);
    logic             fetch_valid;
    logic [31:0]      fetch_pc;
    logic [GHR_W-1:0] fetch_ghr;
    logic [95:0]      fetch_weights;
    logic [7:0]       fetch_sum;
    logic             fetch_pred_dir;
    logic             resolve_valid;
    logic [31:0]      resolve_pc4;
    logic             resolve_dir;
    logic             flush;
    logic             full;
    logic             update_valid;
    logic [31:0]      update_pc4;
    logic             update_dir;
    logic             update_miss;
    logic [95:0]      update_data;
    logic [2:0]       err_flags;

    modport master (
        output fetch_valid, fetch_pc, fetch_ghr, fetch_weights, fetch_sum, fetch_pred_dir,
        output resolve_valid, resolve_pc4, resolve_dir, flush,
        input  full, update_valid, update_pc4, update_dir, update_miss, update_data, err_flags
    );

    modport slave (
        input  fetch_valid, fetch_pc, fetch_ghr, fetch_weights, fetch_sum, fetch_pred_dir,
        input  resolve_valid, resolve_pc4, resolve_dir, flush,
        output full, update_valid, update_pc4, update_dir, update_miss, update_data, err_flags
    );
endinterface

// File: rtl/bp_perceptron_trainer.sv
// ---------------------------------------------------------------------------
// bp_perceptron_trainer
// Holds an in-order FIFO of prediction snapshots taken at fetch. When execute
// resolves the oldest branch, the head snapshot is popped, checked against
// the resolved PC+4, and (on a misprediction) its weight row is trained by
// +/-1 per weight with 8-bit saturation. The resulting row is presented one
// cycle later on the update outputs for write-back to the HOB/LOB tables.
//
// Ports:
//   clk   : clock
//   reset : synchronous, active-high reset
//   bus   : bp_perceptron_trainer_if.slave (fetch, resolve, flush, update, errors)
//
// Weight packing: w_i = {row[60+3i+2:60+3i], row[5i+4:5i]} (hob in [95:60],
// lob in [59:0]), 8-bit two's complement.
//
// Optional feature: define BP_TRAINER_THRESH_EN to also train when the
// snapshot's |sum| <= THETA (low-confidence correct predictions).
// ---------------------------------------------------------------------------
module bp_perceptron_trainer #(
    parameter int DEPTH = 4,
    parameter int GHR_W = 12,
    parameter int THETA = 37
) (
    input  logic clk,
    input  logic reset,
    bp_perceptron_trainer_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int NUM_W = 12;

    // Snapshot storage
    logic [31:0]      r_pc_mem  [DEPTH];
    logic [GHR_W-1:0] r_ghr_mem [DEPTH];
    logic [95:0]      r_w_mem   [DEPTH];
    logic [7:0]       r_sum_mem [DEPTH];
    logic             r_dir_mem [DEPTH];

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_next;

    logic             r_upd_valid;
    logic [31:0]      r_upd_pc4;
    logic             r_upd_dir;
    logic             r_upd_miss;
    logic [95:0]      r_upd_data;
    logic [2:0]       r_err;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_ovf;
    logic             w_unf;
    logic             w_pc_ok;
    logic             w_pc_err;
    logic             w_upd;

    logic [31:0]      w_head_pc;
    logic [GHR_W-1:0] w_head_ghr;
    logic [95:0]      w_head_w;
    logic [7:0]       w_head_sum;
    logic             w_head_dir;

    logic             w_miss;
    logic             w_thresh;
    logic             w_train;
    logic [8:0]       w_sum_ext;
    logic [8:0]       w_abs9;
    logic [95:0]      w_trained;
    logic [95:0]      w_new_row;

    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);

    // Full is judged on the occupancy before any same-cycle pop.
    assign w_push   = bus.fetch_valid && !w_full && !bus.flush;
    assign w_ovf    = bus.fetch_valid &&  w_full && !bus.flush;
    assign w_pop    = bus.resolve_valid && !w_empty;
    assign w_unf    = bus.resolve_valid &&  w_empty;

    assign w_head_pc  = r_pc_mem[r_rd_ptr];
    assign w_head_ghr = r_ghr_mem[r_rd_ptr];
    assign w_head_w   = r_w_mem[r_rd_ptr];
    assign w_head_sum = r_sum_mem[r_rd_ptr];
    assign w_head_dir = r_dir_mem[r_rd_ptr];

    assign w_pc_ok  = ((w_head_pc + 32'd4) == bus.resolve_pc4);
    assign w_pc_err = w_pop && !w_pc_ok;
    assign w_upd    = w_pop &&  w_pc_ok;

    // |sum| in 9 bits so that -128 maps to +128 rather than wrapping.
    assign w_sum_ext = {w_head_sum[7], w_head_sum};
    assign w_abs9    = w_sum_ext[8] ? (9'd0 - w_sum_ext) : w_sum_ext;
    assign w_thresh  = (w_abs9 <= 9'(THETA));
    assign w_miss    = w_head_dir ^ bus.resolve_dir;

`ifdef BP_TRAINER_THRESH_EN
    assign w_train = w_miss | w_thresh;
`else
    // Threshold term stays elaborated but is masked: miss-only training.
    assign w_train = w_miss | (w_thresh & 1'b0);
`endif

    // Per-weight saturating +/-1 update; t*x_i = +1 exactly when dir == ghr[i].
    genvar gi;
    generate
        for (gi = 0; gi < NUM_W; gi++) begin : g_weight
            logic [7:0] w_old;
            logic [8:0] w_sum9;
            logic [7:0] w_new;
            assign w_old = {w_head_w[60+3*gi +: 3], w_head_w[5*gi +: 5]};
            if (gi < GHR_W) begin : g_hist
                assign w_sum9 = {w_old[7], w_old} +
                                ((bus.resolve_dir == w_head_ghr[gi]) ? 9'h001 : 9'h1FF);
            end else begin : g_nohist
                assign w_sum9 = {w_old[7], w_old};
            end
            // Sign bits disagree only when the 9-bit result left the 8-bit range.
            assign w_new = (w_sum9[8] != w_sum9[7]) ? (w_sum9[8] ? 8'h80 : 8'h7F) : w_sum9[7:0];
            assign w_trained[60+3*gi +: 3] = w_new[7:5];
            assign w_trained[5*gi +: 5]    = w_new[4:0];
        end
    endgenerate

    assign w_new_row = w_train ? w_trained : w_head_w;

    always_comb begin
        w_count_next = r_count;
        if (bus.flush) begin
            w_count_next = '0;
        end else if (w_push && !w_pop) begin
            w_count_next = r_count + CNT_W'(1);
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_mem[r_wr_ptr]  <= bus.fetch_pc;
            r_ghr_mem[r_wr_ptr] <= bus.fetch_ghr;
            r_w_mem[r_wr_ptr]   <= bus.fetch_weights;
            r_sum_mem[r_wr_ptr] <= bus.fetch_sum;
            r_dir_mem[r_wr_ptr] <= bus.fetch_pred_dir;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_upd_valid <= 1'b0;
            r_upd_pc4   <= '0;
            r_upd_dir   <= 1'b0;
            r_upd_miss  <= 1'b0;
            r_upd_data  <= '0;
            r_err       <= '0;
        end else begin
            // A same-cycle resolve has already been captured below; flush
            // then clears whatever is left.
            if (bus.flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count     <= w_count_next;
            r_upd_valid <= w_upd;
            if (w_upd) begin
                r_upd_pc4  <= bus.resolve_pc4;
                r_upd_dir  <= bus.resolve_dir;
                r_upd_miss <= w_miss;
                r_upd_data <= w_new_row;
            end
            r_err <= r_err | {w_pc_err, w_unf, w_ovf};
        end
    end

    assign bus.full         = w_full;
    assign bus.update_valid = r_upd_valid;
    assign bus.update_pc4   = r_upd_pc4;
    assign bus.update_dir   = r_upd_dir;
    assign bus.update_miss  = r_upd_miss;
    assign bus.update_data  = r_upd_data;
    assign bus.err_flags    = r_err;
endmodule

// File: tb/tb_bp_perceptron_trainer.sv
// ---------------------------------------------------------------------------
// tb_bp_perceptron_trainer
// Self-checking bench for bp_perceptron_trainer: directed scenarios plus a
// randomized run, all checked against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_bp_perceptron_trainer;
    localparam int DEPTH = 4;
    localparam int GHR_W = 12;
    localparam int THETA = 37;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bp_perceptron_trainer_if #(.GHR_W(GHR_W)) bus ();

    bp_perceptron_trainer #(.DEPTH(DEPTH), .GHR_W(GHR_W), .THETA(THETA)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] pc;
        logic [11:0] ghr;
        logic [95:0] w;
        logic [7:0]  sum;
        logic        pd;
    } snap_t;

    snap_t       q[$];
    logic        exp_valid;
    logic        exp_dir;
    logic        exp_miss;
    logic [31:0] exp_pc4;
    logic [95:0] exp_data;
    logic [2:0]  exp_err;
    int          n_checks = 0;
    int          n_pass   = 0;

    function automatic int get_w(logic [95:0] row, int i);
        logic signed [7:0] b;
        b = $signed({row[60+3*i +: 3], row[5*i +: 5]});
        return int'(b);
    endfunction

    function automatic logic [95:0] set_w(logic [95:0] row, int i, int v);
        logic [95:0] r;
        logic [7:0]  b;
        r = row;
        b = v[7:0];
        r[60+3*i +: 3] = b[7:5];
        r[5*i +: 5]    = b[4:0];
        return r;
    endfunction

    // Reference training: integer add of t*x_i, clamped to [-128,127].
    function automatic logic [95:0] train_row(logic [95:0] row, logic [11:0] ghr, logic dir);
        logic [95:0] r;
        int t, x, v;
        r = row;
        t = dir ? 1 : -1;
        for (int i = 0; i < 12; i++) begin
            x = ghr[i] ? 1 : -1;
            v = get_w(row, i) + t * x;
            if (v > 127)  v = 127;
            if (v < -128) v = -128;
            r = set_w(r, i, v);
        end
        return r;
    endfunction

    function automatic logic [95:0] rand_row();
        logic [95:0] r;
        int sel;
        r = '0;
        for (int i = 0; i < 12; i++) begin
            sel = $urandom_range(0, 3);
            if (sel == 0)      r = set_w(r, i, 127);
            else if (sel == 1) r = set_w(r, i, -128);
            else               r = set_w(r, i, int'($urandom_range(0, 255)) - 128);
        end
        return r;
    endfunction

    task automatic idle_inputs();
        bus.fetch_valid    = 1'b0;
        bus.fetch_pc       = '0;
        bus.fetch_ghr      = '0;
        bus.fetch_weights  = '0;
        bus.fetch_sum      = '0;
        bus.fetch_pred_dir = 1'b0;
        bus.resolve_valid  = 1'b0;
        bus.resolve_pc4    = '0;
        bus.resolve_dir    = 1'b0;
        bus.flush          = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        q.delete();
        exp_valid = 1'b0; exp_dir = 1'b0; exp_miss = 1'b0;
        exp_pc4 = '0; exp_data = '0; exp_err = '0;
    endtask

    // Drives one cycle of stimulus and advances the reference model.
    task automatic drive_cycle(input logic fv, input logic [31:0] pc, input logic [11:0] ghr,
                               input logic [95:0] w, input logic [7:0] sum, input logic pd,
                               input logic rv, input logic [31:0] pc4, input logic rd,
                               input logic fl);
        snap_t e;
        int    sz, s;
        logic  miss, trn;
        bus.fetch_valid = fv; bus.fetch_pc = pc; bus.fetch_ghr = ghr;
        bus.fetch_weights = w; bus.fetch_sum = sum; bus.fetch_pred_dir = pd;
        bus.resolve_valid = rv; bus.resolve_pc4 = pc4; bus.resolve_dir = rd;
        bus.flush = fl;
        sz = q.size();
        exp_valid = 1'b0;
        if (rv) begin
            if (sz == 0) begin
                exp_err[1] = 1'b1;
            end else begin
                e = q.pop_front();
                if (e.pc + 32'd4 == pc4) begin
                    miss = e.pd ^ rd;
                    trn  = miss;
`ifdef BP_TRAINER_THRESH_EN
                    s = int'($signed(e.sum));
                    if (s < 0) s = -s;
                    if (s <= THETA) trn = 1'b1;
`else
                    s = 0;
`endif
                    exp_valid = 1'b1;
                    exp_pc4   = pc4;
                    exp_dir   = rd;
                    exp_miss  = miss;
                    exp_data  = trn ? train_row(e.w, e.ghr, rd) : e.w;
                end else begin
                    exp_err[2] = 1'b1;
                end
            end
        end
        if (fv && !fl) begin
            if (sz == DEPTH) begin
                exp_err[0] = 1'b1;
            end else begin
                e.pc = pc; e.ghr = ghr; e.w = w; e.sum = sum; e.pd = pd;
                q.push_back(e);
            end
        end
        if (fl) q.delete();
        @(posedge clk);
        #1;
        bus.fetch_valid = 1'b0; bus.resolve_valid = 1'b0; bus.flush = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (bus.update_valid !== 1'b0) $display("FAIL reset_valid got=%0b exp=0", bus.update_valid); else n_pass++;
        n_checks++; if (bus.full !== 1'b0) $display("FAIL reset_full got=%0b exp=0", bus.full); else n_pass++;
        n_checks++; if (bus.err_flags !== 3'b000) $display("FAIL reset_err got=%b exp=000", bus.err_flags); else n_pass++;
        n_checks++; if (bus.update_data !== 96'h0 || bus.update_pc4 !== 32'h0) $display("FAIL reset_data got=%h/%h exp=0", bus.update_data, bus.update_pc4); else n_pass++;
        // Entries queued before a reset must be gone afterwards.
        drive_cycle(1, 32'h80, 12'h0, 96'h0, 8'h0, 0, 0, 0, 0, 0);
        do_reset();
        drive_cycle(0, 0, 0, 0, 0, 0, 1, 32'h84, 0, 0);
        n_checks++; if (bus.update_valid !== 1'b0 || bus.err_flags !== 3'b010) $display("FAIL reset_midstream got=%0b/%b exp=0/010", bus.update_valid, bus.err_flags); else n_pass++;
        $display("txn reset: valid=%0b full=%0b err=%b", bus.update_valid, bus.full, bus.err_flags);
    endtask

    task automatic test_basic_train();
        logic [95:0] k;
        do_reset();
        k = {36'h0, {12{5'b00001}}};
        drive_cycle(1, 32'h40, 12'hFFF, 96'h0, 8'h0, 0, 0, 0, 0, 0);
        drive_cycle(0, 0, 0, 0, 0, 0, 1, 32'h44, 1, 0);
        n_checks++; if (bus.update_valid !== 1'b1 || bus.update_miss !== 1'b1) $display("FAIL basic_valid_miss got=%0b/%0b exp=1/1", bus.update_valid, bus.update_miss); else n_pass++;
        n_checks++; if (bus.update_data !== k) $display("FAIL basic_data got=%h exp=%h", bus.update_data, k); else n_pass++;
        n_checks++; if (bus.update_pc4 !== 32'h44 || bus.update_dir !== 1'b1) $display("FAIL basic_pc4_dir got=%h/%0b exp=44/1", bus.update_pc4, bus.update_dir); else n_pass++;
        drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        n_checks++; if (bus.update_valid !== 1'b0 || bus.update_data !== k) $display("FAIL basic_pulse_hold got=%0b/%h exp=0/%h", bus.update_valid, bus.update_data, k); else n_pass++;
        $display("txn basic: data=%h", bus.update_data);
    endtask

    task automatic test_saturation();
        logic [95:0] w;
        do_reset();
        w = set_w(96'h0, 0, 127);
        drive_cycle(1, 32'h100, 12'h001, w, 8'h0, 0, 0, 0, 0, 0);
        drive_cycle(0, 0, 0, 0, 0, 0, 1, 32'h104, 1, 0);
        n_checks++; if (get_w(bus.update_data, 0) != 127 || get_w(bus.update_data, 1) != -1) $display("FAIL sat_pos got=%0d/%0d exp=127/-1", get_w(bus.update_data, 0), get_w(bus.update_data, 1)); else n_pass++;
        w = set_w(96'h0, 0, -128);
        drive_cycle(1, 32'h200, 12'h001, w, 8'h0, 1, 0, 0, 0, 0);
        drive_cycle(0, 0, 0, 0, 0, 0, 1, 32'h204, 0, 0);
        n_checks++; if (get_w(bus.update_data, 0) != -128 || get_w(bus.update_data, 1) != 1) $display("FAIL sat_neg got=%0d/%0d exp=-128/1", get_w(bus.update_data, 0), get_w(bus.update_data, 1)); else n_pass++;
        n_checks++; if (bus.update_data !== exp_data) $display("FAIL sat_row got=%h exp=%h", bus.update_data, exp_data); else n_pass++;
        $display("txn saturation: w0=%0d", get_w(bus.update_data, 0));
    endtask

    task automatic test_no_train();
        logic [95:0] w, k;
        do_reset();
        w = rand_row();
        drive_cycle(1, 32'h300, 12'(($urandom)), w, 8'd100, 1, 0, 0, 0, 0);
        drive_cycle(0, 0, 0, 0, 0, 0, 1, 32'h304, 1, 0);
        n_checks++; if (bus.update_valid !== 1'b1 || bus.update_miss !== 1'b0 || bus.update_data !== w) $display("FAIL notrain_hi got=%0b/%0b/%h exp=1/0/%h", bus.update_valid, bus.update_miss, bus.update_data, w); else n_pass++;
        w = rand_row();
        drive_cycle(1, 32'h400, 12'h5A5, w, 8'd10, 0, 0, 0, 0, 0);
        drive_cycle(0, 0, 0, 0, 0, 0, 1, 32'h404, 0, 0);
`ifdef BP_TRAINER_THRESH_EN
        k = train_row(w, 12'h5A5, 1'b0);
`else
        k = w;
`endif
        n_checks++; if (bus.update_miss !== 1'b0 || bus.update_data !== k) $display("FAIL thresh_lo got=%0b/%h exp=0/%h", bus.update_miss, bus.update_data, k); else n_pass++;
        $display("txn no_train: data=%h", bus.update_data);
    endtask

    task automatic test_full_overflow();
        logic [31:0] pcs[4];
        do_reset();
        for (int k = 0; k < 4; k++) begin
            pcs[k] = 32'h1000 + 32'(k) * 32'h10;
            drive_cycle(1, pcs[k], 12'($urandom), rand_row(), 8'($urandom), 1'($urandom), 0, 0, 0, 0);
        end
        n_checks++; if (bus.full !== 1'b1) $display("FAIL full_set got=%0b exp=1", bus.full); else n_pass++;
        drive_cycle(1, 32'h2000, 12'h0, 96'h0, 8'h0, 0, 0, 0, 0, 0);
        n_checks++; if (bus.err_flags !== 3'b001 || bus.full !== 1'b1) $display("FAIL overflow got=%b/%0b exp=001/1", bus.err_flags, bus.full); else n_pass++;
        for (int k = 0; k < 4; k++) begin
            drive_cycle(0, 0, 0, 0, 0, 0, 1, pcs[k] + 32'd4, 1'($urandom), 0);
            n_checks++;
            if (bus.update_valid !== 1'b1 || bus.update_pc4 !== pcs[k] + 32'd4 || bus.update_data !== exp_data || bus.update_miss !== exp_miss)
                $display("FAIL drain_%0d got=%0b/%h/%h exp=1/%h/%h", k, bus.update_valid, bus.update_pc4, bus.update_data, pcs[k] + 32'd4, exp_data);
            else n_pass++;
            $display("txn drain %0d: pc4=%h miss=%0b", k, bus.update_pc4, bus.update_miss);
        end
        n_checks++; if (bus.full !== 1'b0) $display("FAIL full_clear got=%0b exp=0", bus.full); else n_pass++;
    endtask

    task automatic test_underflow_pcmismatch();
        do_reset();
        drive_cycle(0, 0, 0, 0, 0, 0, 1, 32'h44, 1, 0);
        n_checks++; if (bus.update_valid !== 1'b0 || bus.err_flags !== 3'b010) $display("FAIL underflow got=%0b/%b exp=0/010", bus.update_valid, bus.err_flags); else n_pass++;
        drive_cycle(1, 32'h500, 12'h0, 96'h0, 8'h0, 0, 0, 0, 0, 0);
        drive_cycle(1, 32'h600, 12'h0, 96'h0, 8'h0, 0, 0, 0, 0, 0);
        drive_cycle(0, 0, 0, 0, 0, 0, 1, 32'h999, 1, 0);
        n_checks++; if (bus.update_valid !== 1'b0 || bus.err_flags !== 3'b110) $display("FAIL pc_mismatch got=%0b/%b exp=0/110", bus.update_valid, bus.err_flags); else n_pass++;
        drive_cycle(0, 0, 0, 0, 0, 0, 1, 32'h604, 1, 0);
        n_checks++; if (bus.update_valid !== 1'b1 || bus.update_pc4 !== 32'h604) $display("FAIL after_mismatch got=%0b/%h exp=1/604", bus.update_valid, bus.update_pc4); else n_pass++;
        $display("txn mismatch: err=%b", bus.err_flags);
    endtask

    task automatic test_flush();
        do_reset();
        for (int k = 0; k < 3; k++)
            drive_cycle(1, 32'h700 + 32'(k) * 32'h8, 12'($urandom), rand_row(), 8'h0, 0, 0, 0, 0, 0);
        drive_cycle(1, 32'h800, 12'h0, 96'h0, 8'h0, 0, 1, 32'h704, 1, 1);
        n_checks++; if (bus.update_valid !== 1'b1 || bus.update_pc4 !== 32'h704 || bus.update_data !== exp_data) $display("FAIL flush_head got=%0b/%h exp=1/704", bus.update_valid, bus.update_pc4); else n_pass++;
        n_checks++; if (bus.full !== 1'b0 || bus.err_flags !== 3'b000) $display("FAIL flush_state got=%0b/%b exp=0/000", bus.full, bus.err_flags); else n_pass++;
        drive_cycle(0, 0, 0, 0, 0, 0, 1, 32'h804, 0, 0);
        n_checks++; if (bus.update_valid !== 1'b0 || bus.err_flags !== 3'b010) $display("FAIL flush_empty got=%0b/%b exp=0/010", bus.update_valid, bus.err_flags); else n_pass++;
        $display("txn flush: err=%b", bus.err_flags);
    endtask

    task automatic test_random();
        logic        fv, rv, fl, rd;
        logic [31:0] pc4;
        do_reset();
        for (int n = 0; n < 200; n++) begin
            fv  = ($urandom_range(0, 9) < 6);
            rv  = ($urandom_range(0, 9) < 5);
            fl  = ($urandom_range(0, 99) < 3);
            rd  = 1'($urandom);
            pc4 = $urandom;
            if (q.size() > 0 && $urandom_range(0, 9) != 0) pc4 = q[0].pc + 32'd4;
            drive_cycle(fv, {$urandom_range(0, 65535), 2'b00}, 12'($urandom), rand_row(),
                        8'($urandom), 1'($urandom), rv, pc4, rd, fl);
            n_checks++;
            if (bus.update_valid !== exp_valid || bus.full !== (q.size() == DEPTH) || bus.err_flags !== exp_err)
                $display("FAIL rand_ctrl_%0d got=%0b/%0b/%b exp=%0b/%0b/%b", n, bus.update_valid, bus.full, bus.err_flags, exp_valid, (q.size() == DEPTH), exp_err);
            else n_pass++;
            n_checks++;
            if (bus.update_pc4 !== exp_pc4 || bus.update_data !== exp_data || bus.update_miss !== exp_miss || bus.update_dir !== exp_dir)
                $display("FAIL rand_data_%0d got=%h/%h/%0b/%0b exp=%h/%h/%0b/%0b", n, bus.update_pc4, bus.update_data, bus.update_miss, bus.update_dir, exp_pc4, exp_data, exp_miss, exp_dir);
            else n_pass++;
            $display("txn rand %0d: push=%0b res=%0b fl=%0b valid=%0b occ=%0d", n, fv, rv, fl, bus.update_valid, q.size());
        end
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_basic_train();
        test_saturation();
        test_no_train();
        test_full_overflow();
        test_underflow_pcmismatch();
        test_flush();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/bp_perceptron_trainer.md
Name: bp_perceptron_trainer

Overview:
- Sits between fetch and execute. Feeds the predictor update port (wren, PC, 96-bit weight data).
- Captures a snapshot of each prediction made at fetch: PC, GHR, weight row, perceptron sum and predicted direction. Holds the snapshots in order in a small FIFO.
- When execute resolves the oldest branch, computes the trained weight row and presents it for write-back to the HOB and LOB tables.

Parameters:
- DEPTH, 4, in-flight prediction FIFO entries (power of two, >= 2)
- GHR_W, 12, global history length; number of weights
- THETA, 37, training threshold on |sum| (used only when the optional feature is compiled in)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- fetch_valid  in  1  push one prediction snapshot
- fetch_pc  in  32  PC of the predicted branch
- fetch_ghr  in  GHR_W  GHR used for the prediction
- fetch_weights  in  96  weight row read at fetch: {hob[35:0], lob[59:0]}
- fetch_sum  in  8  signed perceptron sum
- fetch_pred_dir  in  1  predicted direction
- resolve_valid  in  1  oldest branch resolved this cycle
- resolve_pc4  in  32  PC+4 of the resolved branch
- resolve_dir  in  1  actual direction
- flush  in  1  discard all in-flight snapshots
- full  out  1  FIFO full; fetch must not push
- update_valid  out  1  update outputs valid for one cycle
- update_pc4  out  32  PC+4 for write address
- update_dir  out  1  actual direction
- update_miss  out  1  prediction was wrong
- update_data  out  96  trained weight row, same packing as fetch_weights
- err_flags  out  3  sticky {pc_mismatch, underflow, overflow}

Behaviour:
- Weight packing:
  - Weight i is 8-bit signed: w_i = {hob[3i+2:3i], lob[5i+4:5i]}.
  - hob occupies bits [95:60] of the 96-bit bus; lob occupies bits [59:0].
- FIFO:
  - Circular buffer, DEPTH entries, with read/write pointers and an occupancy count of log2(DEPTH)+1 bits.
  - Pointers wrap modulo DEPTH.
  - full = (count == DEPTH).
- Push: accepted when fetch_valid && !full && !flush.
  - Push while full: dropped, and err_flags[0] sets.
- Resolve: when resolve_valid && count != 0, pop the head entry.
  - Resolve with count == 0: ignored, no update, err_flags[1] sets.
- Push and pop in the same cycle are both legal; count is unchanged. Push while full is still refused in that cycle, even if a pop also occurs.
- PC check:
  - If the popped entry's pc + 4 != resolve_pc4, the entry is discarded, no update is issued, and err_flags[2] sets.
- Training decision for a popped entry that passes the PC check:
  - miss = pred_dir ^ resolve_dir.
  - train = miss, OR-ed with the threshold term when the optional feature is enabled.
- Weight update when train:
  - t = +1 if resolve_dir, else -1.
  - x_i = +1 if ghr[i], else -1.
  - w_i' = sat8(w_i + t*x_i), saturating to [-128, +127].
  - When not training, update_data = snapshot weights unchanged.
- Latency and outputs:
  - Outputs are registered: a resolve in cycle N gives update_valid = 1 in cycle N+1, for exactly one cycle.
  - update_valid = 1 for every popped, PC-matched entry, whether or not it trained.
  - Pulses are back-to-back when resolves are back-to-back.
- Flush:
  - A resolve in the same cycle is processed first, then all remaining entries are cleared: pointers and count go to 0.
  - A push in the flush cycle is dropped and does not set overflow.
- Reset:
  - FIFO empties.
  - update_valid, update_miss, update_dir = 0; update_pc4, update_data = 0; err_flags = 0.
  - full = 0 in the first cycle after reset.
  - A reset mid-stream discards all in-flight entries and any pending update.
- Registered outputs hold their last value while update_valid = 0.

Optional Feature:
- Macro: BP_TRAINER_THRESH_EN.
- Defined: train = miss || (|fetch_sum| <= THETA), with |sum| computed in 9 bits so that -128 is handled.
- Undefined: train = miss only, and THETA is unused.

Test Plan:
- Push pc=0x40, ghr=0xFFF, all w=0, pred_dir=0, sum=0; resolve pc4=0x44, dir=1 -> cycle N+1: update_valid=1, miss=1, every w_i=+1 (hob=3'b000, lob=5'b00001 per slot).
- Entry with w_0=+127, ghr[0]=1, miss, dir=1 -> w_0 stays 127. Same with w_0=-128, ghr[0]=1, dir=0 -> w_0 stays -128.
- Correct prediction with sum=+100 -> update_miss=0, data equal to snapshot. Sum=+10 with BP_TRAINER_THRESH_EN defined -> weights trained; undefined -> unchanged.
- Push 4 entries (DEPTH=4) -> full=1; 5th push -> dropped, err_flags=3'b001. Then resolve 4 times -> 4 consecutive update pulses in FIFO order.
- Resolve with empty FIFO -> no update_valid, err_flags[1]=1. Resolve pc4 mismatching head -> entry dropped, err_flags[2]=1, next resolve pops the following entry.
- 3 entries queued; flush together with resolve -> one update issued for the head, count=0 next cycle, full=0. Simultaneous push in that cycle -> not stored.
